// File: rtl/md5_core_scheduler_if.sv
// Stream of candidate blocks from the extractor plus the shared md5 core start/done bus.
// slave = scheduler side, master = extractor / core-array side.
interface md5_core_scheduler_if #(
  parameter int NUM_UNITS = 4,
  parameter int MSG_WIDTH = 512,
  parameter int IDX_WIDTH = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [MSG_WIDTH-1:0] s_data;
  logic [IDX_WIDTH-1:0] s_index;
  logic                 s_last;
  logic [NUM_UNITS-1:0] core_start;
  logic [MSG_WIDTH-1:0] core_data;
  logic [NUM_UNITS-1:0] core_done;
  logic [NUM_UNITS-1:0] core_match;

  modport slave (
    input  s_valid, s_data, s_index, s_last, core_done, core_match,
    output s_ready, core_start, core_data
  );

  modport master (
    output s_valid, s_data, s_index, s_last, core_done, core_match,
    input  s_ready, core_start, core_data
  );
endinterface

// File: rtl/md5_core_scheduler.sv
// Round-robin dispatch of message blocks to NUM_UNITS md5 cores (start 1 cycle after accept), s_ready low while all busy;
// tracks lowest matching index. Macro MD5_SCHED_EARLY_STOP_EN stops dispatch at the first match.
module md5_core_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int MSG_WIDTH = 512,
  parameter int IDX_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  md5_core_scheduler_if.slave  bus,
  output logic                 match_found,
  output logic [IDX_WIDTH-1:0] match_index,
  output logic [7:0]           match_count,
  output logic                 job_done,
  output logic                 protocol_err
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [NUM_UNITS-1:0] pending, pending_nxt;
  logic [NUM_UNITS-1:0] sel_onehot, done_ok, hit;
  logic [PTR_W-1:0]     rr_ptr, sel_idx, cand;
  logic [IDX_WIDTH-1:0] idx_reg [NUM_UNITS];
  logic [IDX_WIDTH-1:0] hit_min;
  logic [3:0]           hit_cnt;
  logic [8:0]           cnt_sum;
  logic [7:0]           cnt_sat;
  logic [NUM_UNITS-1:0] start_q;
  logic [MSG_WIDTH-1:0] data_q;
  logic                 any_free, accept, err_now;

  // First free unit at or above rr_ptr, wrapping; uses pre-clear pending so a
  // unit freed this cycle only becomes selectable next cycle.
  always_comb begin
    any_free = 1'b0;
    sel_idx  = '0;
    cand     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_UNITS);
      if (!any_free && !pending[cand]) begin
        any_free = 1'b1;
        sel_idx  = cand;
      end
    end
    sel_onehot = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      sel_onehot[u] = any_free && (sel_idx == PTR_W'(u));
    end
  end

  assign bus.s_ready    = (state == RUN) && any_free;
  assign accept         = bus.s_valid && bus.s_ready;
  assign bus.core_start = start_q;
  assign bus.core_data  = data_q;
  assign job_done       = (state == DONE);

  assign done_ok = bus.core_done & pending;
  assign hit     = done_ok & bus.core_match;
  assign err_now = |(bus.core_done & ~pending);

  always_comb begin
    hit_min = match_index;
    hit_cnt = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (hit[u]) begin
        hit_cnt = hit_cnt + 4'd1;
        if (idx_reg[u] < hit_min) hit_min = idx_reg[u];
      end
    end
    cnt_sum = {1'b0, match_count} + 9'(hit_cnt);
    cnt_sat = (cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0];
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = RUN;
        RUN: begin
          if (accept && bus.s_last) state_nxt = DRAIN;
`ifdef MD5_SCHED_EARLY_STOP_EN
          if (|hit) state_nxt = DRAIN;
`endif
        end
        DRAIN: if ((pending & ~bus.core_done) == '0) state_nxt = DONE;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pending_nxt = (pending & ~bus.core_done) | (accept ? sel_onehot : '0);
    if (!enable) pending_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      rr_ptr       <= '0;
      start_q      <= '0;
      data_q       <= '0;
      match_found  <= 1'b0;
      match_index  <= '1;
      match_count  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      start_q <= accept ? sel_onehot : '0;
      if (accept) begin
        data_q <= bus.s_data;
        rr_ptr <= (sel_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : sel_idx + PTR_W'(1);
      end
      if (state == IDLE && enable) begin
        match_found  <= 1'b0;
        match_index  <= '1;
        match_count  <= '0;
        protocol_err <= err_now;
      end else begin
        if (|hit) begin
          match_found <= 1'b1;
          match_index <= hit_min;
          match_count <= cnt_sat;
        end
        if (err_now) protocol_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) idx_reg[sel_idx] <= bus.s_index;
  end
endmodule

// File: tb/tb_md5_core_scheduler.sv
// Directed bench for md5_core_scheduler: job vector table plus hand sequences for
// simultaneous matches, backpressure, abort/protocol error and early stop.
module tb_md5_core_scheduler;
  localparam int NU = 4;
  localparam int MW = 512;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          match_found;
  logic [IW-1:0] match_index;
  logic [7:0]    match_count;
  logic          job_done;
  logic          protocol_err;

  always #5 clk = ~clk;

  md5_core_scheduler_if #(.NUM_UNITS(NU), .MSG_WIDTH(MW), .IDX_WIDTH(IW)) bus ();

  md5_core_scheduler #(.NUM_UNITS(NU), .MSG_WIDTH(MW), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus.slave),
    .match_found  (match_found),
    .match_index  (match_index),
    .match_count  (match_count),
    .job_done     (job_done),
    .protocol_err (protocol_err)
  );

  typedef struct {
    int          n;
    logic [31:0] idx [8];
    logic [7:0]  mmask;
    bit          e_found;
    logic [31:0] e_idx;
    int          e_cnt;
  } vec_t;

  vec_t vt [5];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          auto_core = 0;
  int          lat      = 20;
  logic [31:0] mlist [$];
  int          cnt  [NU];
  logic [31:0] cidx [NU];
  bit          cbusy [NU];
  logic [NU-1:0] start_log [$];
  int          last_start_cyc;
  bit          rdy_smp, acc;
  bit          mf_seen;
  int          mf_cyc;
  logic        ready_after;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_match(input logic [31:0] i);
    foreach (mlist[k]) if (mlist[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample handshake at negedge, then advance and run the core model.
  task automatic tick();
    @(negedge clk);
    rdy_smp = bus.s_ready;
    acc     = bus.s_valid && bus.s_ready;
    @(posedge clk);
    #1;
    cyc++;
    bus.core_done  = '0;
    bus.core_match = '0;
    if (bus.core_start != '0) begin
      start_log.push_back(bus.core_start);
      last_start_cyc = cyc;
    end
    if (match_found && !mf_seen) begin
      mf_seen     = 1'b1;
      mf_cyc      = cyc;
      ready_after = bus.s_ready;
    end
    if (auto_core) begin
      for (int u = 0; u < NU; u++) begin
        if (cbusy[u]) begin
          cnt[u]--;
          if (cnt[u] == 0) begin
            bus.core_done[u]  = 1'b1;
            bus.core_match[u] = is_match(cidx[u]);
            cbusy[u] = 1'b0;
          end
        end
        if (bus.core_start[u]) begin
          cbusy[u] = 1'b1;
          cnt[u]   = lat;
          cidx[u]  = bus.core_data[31:0];
        end
      end
    end
  endtask

  task automatic feed(input logic [31:0] idx, input bit last, output bit ok);
    bus.s_valid = 1'b1;
    bus.s_data  = {16{idx}};
    bus.s_index = idx;
    bus.s_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok && !job_done; t++) begin
      tick();
      ok = acc;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 400 && !job_done; t++) tick();
    chk(name, job_done, 1);
  endtask

  task automatic start_job();
    enable = 1'b1;
    tick();
    mf_seen = 1'b0;
    last_start_cyc = 0;
    start_log.delete();
  endtask

  task automatic end_job();
    enable = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n_acc;
    int c0;

    for (int i = 0; i < 8; i++) vt[0].idx[i] = 32'(i);
    vt[0].n = 8; vt[0].mmask = 8'h00; vt[0].e_found = 0; vt[0].e_idx = 32'hFFFF_FFFF; vt[0].e_cnt = 0;
    vt[1].n = 4; vt[1].idx[0] = 32'hA3C; vt[1].idx[1] = 32'hA3D; vt[1].idx[2] = 32'hA3E; vt[1].idx[3] = 32'hA3F;
    vt[1].mmask = 8'b1000; vt[1].e_found = 1; vt[1].e_idx = 32'hA3F; vt[1].e_cnt = 1;
    vt[2].n = 4; vt[2].idx[0] = 32'h20; vt[2].idx[1] = 32'h1F; vt[2].idx[2] = 32'h1E; vt[2].idx[3] = 32'h1B;
    vt[2].mmask = 8'b1010; vt[2].e_found = 1; vt[2].e_idx = 32'h1B; vt[2].e_cnt = 2;
    vt[3].n = 1; vt[3].idx[0] = 32'hFFFF_FFFF;
    vt[3].mmask = 8'b0001; vt[3].e_found = 1; vt[3].e_idx = 32'hFFFF_FFFF; vt[3].e_cnt = 1;
    vt[4].n = 3; vt[4].idx[0] = 32'h5; vt[4].idx[1] = 32'h0; vt[4].idx[2] = 32'h9;
    vt[4].mmask = 8'b0111; vt[4].e_found = 1; vt[4].e_idx = 32'h0; vt[4].e_cnt = 3;
    for (int v = 0; v < 5; v++)
      for (int i = vt[v].n; i < 8; i++) vt[v].idx[i] = '0;

    reset = 1'b1; enable = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = '0; bus.s_index = '0; bus.s_last = 1'b0;
    bus.core_done = '0; bus.core_match = '0;
    for (int u = 0; u < NU; u++) begin cbusy[u] = 0; cnt[u] = 0; cidx[u] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("rst_s_ready_idle_valid", bus.s_ready, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_data", bus.core_data[63:0], 0);
    chk("rst_match_found", match_found, 0);
    chk("rst_match_index", match_index, 32'hFFFF_FFFF);
    chk("rst_match_count", match_count, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_protocol_err", protocol_err, 0);
    bus.s_valid = 1'b0;

    // Job vector table with auto-responding cores (done 20 cycles after start)
    auto_core = 1;
    for (int v = 0; v < 5; v++) begin
      mlist.delete();
      for (int i = 0; i < vt[v].n; i++) if (vt[v].mmask[i]) mlist.push_back(vt[v].idx[i]);
      start_job();
      for (int i = 0; i < vt[v].n; i++) begin
        feed(vt[v].idx[i], i == vt[v].n - 1, ok);
        chk($sformatf("vec%0d_accept%0d", v, i), ok, 1);
      end
      wait_done($sformatf("vec%0d_job_done", v));
      chk($sformatf("vec%0d_match_found", v), match_found, vt[v].e_found);
      chk($sformatf("vec%0d_match_index", v), match_index, vt[v].e_idx);
      chk($sformatf("vec%0d_match_count", v), match_count, vt[v].e_cnt);
      if (v == 0) begin
        chk("rr_start_count", start_log.size(), 8);
        for (int i = 0; i < 8 && i < start_log.size(); i++)
          chk($sformatf("rr_start%0d", i), start_log[i], 4'b0001 << (i % 4));
      end
      end_job();
    end
    auto_core = 0;

    // Simultaneous and out-of-order matches; units 0..3 hold 0x30,0x15,0x44,0x12
    start_job();
    feed(32'h30, 0, ok);
    chk("sim_start_u0", bus.core_start, 4'b0001);
    chk("sim_core_data", bus.core_data[63:0], 64'h0000_0030_0000_0030);
    feed(32'h15, 0, ok);
    chk("sim_start_u1", bus.core_start, 4'b0010);
    feed(32'h44, 0, ok);
    chk("sim_start_u2", bus.core_start, 4'b0100);
    feed(32'h12, 1, ok);
    chk("sim_start_u3", bus.core_start, 4'b1000);
    bus.core_done = 4'b1010; bus.core_match = 4'b1010;
    tick();
    chk("sim_pair_index", match_index, 32'h12);
    chk("sim_pair_count", match_count, 2);
    bus.core_done = 4'b0001; bus.core_match = 4'b0001;
    tick();
    chk("sim_late_index", match_index, 32'h12);
    chk("sim_late_count", match_count, 3);
    chk("sim_not_done_yet", job_done, 0);
    bus.core_done = 4'b0100; bus.core_match = 4'b0000;
    tick();
    chk("sim_done_same_cycle_drain", job_done, 1);
    chk("sim_found", match_found, 1);
    end_job();

    // Backpressure: all four pending, fifth block waits for a freed unit
    start_job();
    for (int i = 0; i < 4; i++) begin
      feed(32'h100 + 32'(i), 0, ok);
      chk($sformatf("bp_fill%0d", i), bus.core_start, 4'b0001 << i);
    end
    bus.s_valid = 1'b1; bus.s_data = {16{32'h104}}; bus.s_index = 32'h104; bus.s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_stall%0d", i), rdy_smp, 0);
    end
    bus.core_done = 4'b0100;
    tick();
    chk("bp_freed_not_same_cycle", rdy_smp, 0);
    tick();
    chk("bp_ready_next_cycle", rdy_smp, 1);
    chk("bp_accept", acc, 1);
    chk("bp_freed_unit_start", bus.core_start, 4'b0100);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.core_done = 4'b1111;
    tick();
    chk("bp_job_done", job_done, 1);
    chk("bp_no_err", protocol_err, 0);
    end_job();

    // Abort with units pending, then protocol error on an idle unit
    start_job();
    feed(32'h50, 0, ok);
    chk("ab_start_u3", bus.core_start, 4'b1000);
    feed(32'h51, 0, ok);
    chk("ab_start_u0", bus.core_start, 4'b0001);
    feed(32'h52, 0, ok);
    chk("ab_start_u1", bus.core_start, 4'b0010);
    bus.core_done = 4'b0001; bus.core_match = 4'b0001;
    tick();
    chk("ab_match_index", match_index, 32'h51);
    enable = 1'b0;
    tick();
    chk("ab_idle_ready", bus.s_ready, 0);
    chk("ab_idle_job_done", job_done, 0);
    chk("ab_hold_found", match_found, 1);
    chk("ab_hold_index", match_index, 32'h51);
    chk("ab_hold_count", match_count, 1);
    enable = 1'b1;
    tick();
    chk("ab_clr_found", match_found, 0);
    chk("ab_clr_index", match_index, 32'hFFFF_FFFF);
    chk("ab_clr_count", match_count, 0);
    chk("ab_clr_err", protocol_err, 0);
    chk("ab_run_ready", bus.s_ready, 1);
    bus.core_done = 4'b0100;
    tick();
    chk("ab_protocol_err", protocol_err, 1);
    c0 = cyc;
    for (int i = 0; i < 4; i++) feed(32'h60 + 32'(i), 0, ok);
    chk("ab_pending_cleared", cyc - c0, 4);
    chk("ab_err_sticky", protocol_err, 1);
    chk("ab_no_match_from_err", match_found, 0);
    end_job();

    // Long stream with a single match on index 5
    auto_core = 1;
    mlist.delete();
    mlist.push_back(32'h5);
    start_job();
    n_acc = 0;
`ifdef MD5_SCHED_EARLY_STOP_EN
    for (int i = 0; i < 100 && !job_done; i++) begin
      feed(32'(i), i == 99, ok);
      if (ok) n_acc++;
    end
    wait_done("es_job_done");
    chk("es_stopped_early", n_acc < 100, 1);
    chk("es_ready_after_match", ready_after, 0);
    chk("es_no_start_after_match", last_start_cyc <= mf_cyc, 1);
`else
    for (int i = 0; i < 12; i++) begin
      feed(32'(i), i == 11, ok);
      if (ok) n_acc++;
    end
    wait_done("full_job_done");
    chk("full_all_accepted", n_acc, 12);
    chk("full_starts", start_log.size(), 12);
`endif
    chk("stream_match_found", match_found, 1);
    chk("stream_match_index", match_index, 32'h5);
    chk("stream_match_count", match_count, 1);
    end_job();
    auto_core = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/md5_core_scheduler.md
Name: md5_core_scheduler

Overview:
- Dispatches candidate message blocks from the string extractor to NUM_UNITS parallel md5 cores. Issue order is round-robin.
- Tracks the text index of each in-flight block and collects core match results.
- Reports the lowest matching index to the command parser, which serves CMD_READ_MATCH_OP (0x03).
- Sits between the string-extraction stage and the md5 core array inside top_md5.

Parameters:
- NUM_UNITS, 4, number of md5 cores scheduled (1..8).
- MSG_WIDTH, 512, width of one padded md5 message block.
- IDX_WIDTH, 32, width of the text byte index attached to each block.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  job enable from cmd_parser. High for the duration of a CMD_SEND_TEXT_OP job.
- s_valid  in  1  candidate block valid.
- s_ready  out  1  scheduler can accept a block.
- s_data  in  MSG_WIDTH  candidate block.
- s_index  in  IDX_WIDTH  text index of the candidate.
- s_last  in  1  final candidate of the job.
- core_start  out  NUM_UNITS  one-hot, one-cycle start pulse per core.
- core_data  out  MSG_WIDTH  block bus shared by all cores. Valid only while core_start is nonzero.
- core_done  in  NUM_UNITS  one-cycle completion pulse per core.
- core_match  in  NUM_UNITS  match flag, qualified by the matching core_done bit.
- match_found  out  1  at least one match reported in the current job.
- match_index  out  IDX_WIDTH  lowest matching index seen in the current job.
- match_count  out  8  number of matches in the job. Saturates at 255.
- job_done  out  1  job complete and all cores drained.
- protocol_err  out  1  sticky: core_done received from a non-pending unit.

Behaviour:
- Reset:
  - state=IDLE; pending=0; rr_ptr=0.
  - core_start=0; core_data=0; s_ready=0.
  - match_found=0; match_index={IDX_WIDTH{1'b1}}; match_count=0.
  - job_done=0; protocol_err=0.
- States:
  - IDLE -> RUN on enable=1. The same edge clears match_found, match_index (to all-ones), match_count and protocol_err.
  - RUN -> DRAIN on acceptance of a block with s_last=1.
  - DRAIN -> DONE when pending==0, including any done pulse arriving in that same cycle.
  - DONE -> IDLE when enable=0.
  - Any state -> IDLE when enable=0. Pending is cleared; match outputs hold their values.
- s_ready (combinational) = (state==RUN) && (at least one unit has pending==0).
- Accept happens on s_valid && s_ready.
  - Unit selection: first non-pending unit searching upward from rr_ptr, with wrap-around.
  - Next cycle (registered, latency 1): core_start[u]=1, core_data=s_data, idx_reg[u]=s_index, pending[u]=1, rr_ptr=(u+1) mod NUM_UNITS.
  - Maximum issue rate is one block per cycle.
- A unit freed by core_done in cycle N is selectable for an accept in cycle N+1, not in cycle N.
- core_done[u] with pending[u]=1:
  - pending[u] is cleared.
  - If core_match[u]=1: match_found=1, match_count increments (saturating), and match_index=min(match_index, idx_reg[u]).
- Multiple core_done bits in one cycle are all processed in that cycle:
  - match_index takes the minimum over all matching units and the current value.
  - match_count adds the number of matches, saturating at 255.
- core_done[u] with pending[u]=0 is ignored and sets protocol_err.
- job_done=1 exactly while in DONE.
- s_valid while not in RUN is not accepted; data is held upstream.
- Index arithmetic is unsigned. All-ones is a legal index, but with match_found=0 it means "no match".

Optional Feature:
- Macro: MD5_SCHED_EARLY_STOP_EN.
- Defined:
  - The first processed match in RUN forces s_ready=0 from the next cycle and transitions RUN -> DRAIN without waiting for s_last.
  - In-flight units still complete, and their matches still update match_index and match_count.
- Undefined: matches never alter dispatch; the full stream is consumed until s_last.

Test Plan:
1. Round-robin order:
   - Stimulus: NUM_UNITS=4, all cores done 20 cycles after start, 8 blocks (indices 0..7) back-to-back, s_last on index 7.
   - Required: core_start sequence 0001,0010,0100,1000, then 0001.. once units free; job_done=1; match_found=0; match_index=FFFFFFFF.
2. Single match:
   - Stimulus: unit holding index 0x00000A3F returns core_match=1.
   - Required: match_found=1, match_index=0x00000A3F, match_count=1 after DONE.
3. Simultaneous and out-of-order matches:
   - Stimulus: units 1 and 3 (indices 0x15, 0x12) pulse done+match in the same cycle; later unit 0 (index 0x30) matches.
   - Required: match_index=0x12, match_count=3.
4. Backpressure:
   - Stimulus: all 4 units pending while s_valid=1.
   - Required: s_ready=0 until a core_done pulse; the block is accepted the following cycle into the freed unit.
5. Abort and error:
   - Stimulus: drop enable mid-RUN with 2 units pending, then re-raise enable and pulse core_done[2] while nothing is pending.
   - Required: state returns to IDLE, then RUN; pending=0; match outputs cleared on the re-enable; protocol_err=1.
6. With MD5_SCHED_EARLY_STOP_EN:
   - Stimulus: match on index 5 of a 100-block stream.
   - Required: s_ready falls the cycle after the match; no further core_start pulses; job_done asserts after in-flight units drain; match_index=5.
